vram_arbiter: RTL and testbench

Shares the single-port 2048x8 synchronous character VRAM between the display fetch path and a host (CPU/debug) port, and optionally runs a hardware screen-clear. Display reads always win, so scan-out timing is unchanged. Host accesses are queued in a small command FIFO and issued on cycles the display leaves free. Sits between the character display engine, the host bus bridge, and the VRAM macro.

---
 rtl/vram_arbiter_if.sv | 38 +++
 rtl/vram_arbiter.sv | 149 ++++++++++++++
 tb/tb_vram_arbiter.sv | 388 ++++++++++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/vram_arbiter_if.sv
// Bundle of display, host, clear and VRAM-macro signals seen by vram_arbiter.
// The slave modport is the arbiter's view; master is the surrounding system's view.
interface vram_arbiter_if #(
   parameter int unsigned AW = 11,
   parameter int unsigned DW = 8
);
   logic          disp_req;
   logic [AW-1:0] disp_addr;
   logic [DW-1:0] disp_data;
   logic          host_valid;
   logic          host_ready;
   logic          host_we;
   logic [AW-1:0] host_addr;
   logic [DW-1:0] host_wdata;
   logic          host_rvalid;
   logic [DW-1:0] host_rdata;
   logic          clr_start;
   logic [DW-1:0] clr_value;
   logic          clr_busy;
   logic [AW-1:0] sram_addr;
   logic          sram_we;
   logic [DW-1:0] sram_wdata;
   logic [DW-1:0] sram_rdata;

   modport slave (
      input  disp_req, disp_addr, host_valid, host_we, host_addr, host_wdata,
             clr_start, clr_value, sram_rdata,
      output disp_data, host_ready, host_rvalid, host_rdata, clr_busy,
             sram_addr, sram_we, sram_wdata
   );

   modport master (
      output disp_req, disp_addr, host_valid, host_we, host_addr, host_wdata,
             clr_start, clr_value, sram_rdata,
      input  disp_data, host_ready, host_rvalid, host_rdata, clr_busy,
             sram_addr, sram_we, sram_wdata
   );
endinterface

// File: rtl/vram_arbiter.sv
// Single-port VRAM arbiter: display reads first, queued host commands next, then fill.
// Define VRAM_CLEAR_EN to build the hardware screen-clear engine (DRAIN/CLEAR FSM).
module vram_arbiter #(
   parameter int unsigned AW    = 11,
   parameter int unsigned DW    = 8,
   parameter int unsigned DEPTH = 4
) (
   input  logic                clk,
   input  logic                rst,
   vram_arbiter_if.slave       bus
);
   localparam int unsigned PW = $clog2(DEPTH);
   localparam int unsigned EW = 1 + AW + DW;

   logic [EW-1:0] r_fifo [DEPTH];
   logic [PW:0]   r_wptr;
   logic [PW:0]   r_rptr;
   logic          r_last_disp;
   logic          r_host_rd;
   logic [DW-1:0] r_disp_hold;

   logic          w_empty;
   logic          w_full;
   logic          w_push;
   logic          w_pop;
   logic [EW-1:0] w_head;
   logic          w_head_we;
   logic [AW-1:0] w_head_addr;
   logic [DW-1:0] w_head_wdata;
   logic          w_clr_slot;
   logic [AW-1:0] w_clr_addr;
   logic [DW-1:0] w_clr_val;

   assign w_empty      = (r_wptr == r_rptr);
   assign w_full       = (r_wptr[PW] != r_rptr[PW]) && (r_wptr[PW-1:0] == r_rptr[PW-1:0]);
   assign w_head       = r_fifo[r_rptr[PW-1:0]];
   assign w_head_we    = w_head[EW-1];
   assign w_head_addr  = w_head[AW+DW-1:DW];
   assign w_head_wdata = w_head[DW-1:0];
   assign w_push       = bus.host_valid & bus.host_ready;
   assign w_pop        = !bus.disp_req & !w_empty;

   // Storage carries no reset; validity is tracked by the pointers alone.
   always_ff @(posedge clk) begin
      if (w_push) begin
         r_fifo[r_wptr[PW-1:0]] <= {bus.host_we, bus.host_addr, bus.host_wdata};
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_wptr      <= '0;
         r_rptr      <= '0;
         r_last_disp <= 1'b0;
         r_host_rd   <= 1'b0;
         r_disp_hold <= '0;
      end else begin
         if (w_push) r_wptr <= r_wptr + (PW+1)'(1);
         if (w_pop)  r_rptr <= r_rptr + (PW+1)'(1);
         r_last_disp <= bus.disp_req;
         r_host_rd   <= w_pop & !w_head_we;
         if (r_last_disp) r_disp_hold <= bus.sram_rdata;
      end
   end

   assign bus.disp_data   = r_last_disp ? bus.sram_rdata : r_disp_hold;
   assign bus.host_rvalid = r_host_rd;
   assign bus.host_rdata  = bus.sram_rdata;

`ifdef VRAM_CLEAR_EN
   typedef enum logic [1:0] {StIdle, StDrain, StClear} state_e;

   state_e        r_state, w_state_next;
   logic [AW-1:0] r_clr_addr, w_clr_addr_next;
   logic [DW-1:0] r_clr_val, w_clr_val_next;

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_state    <= StIdle;
         r_clr_addr <= '0;
         r_clr_val  <= '0;
      end else begin
         r_state    <= w_state_next;
         r_clr_addr <= w_clr_addr_next;
         r_clr_val  <= w_clr_val_next;
      end
   end

   // FIFO is necessarily empty in CLEAR since host_ready is held low from DRAIN on.
   assign w_clr_slot = (r_state == StClear) & !bus.disp_req & w_empty;

   always_comb begin
      w_state_next    = r_state;
      w_clr_addr_next = r_clr_addr;
      w_clr_val_next  = r_clr_val;
      unique case (r_state)
         StIdle: begin
            if (bus.clr_start) begin
               w_state_next   = StDrain;
               w_clr_val_next = bus.clr_value;
            end
         end
         StDrain: begin
            if (w_empty) begin
               w_state_next    = StClear;
               w_clr_addr_next = '0;
            end
         end
         StClear: begin
            if (w_clr_slot) begin
               w_clr_addr_next = r_clr_addr + AW'(1);
               if (r_clr_addr == {AW{1'b1}}) w_state_next = StIdle;
            end
         end
         default: w_state_next = StIdle;
      endcase
   end

   assign w_clr_addr     = r_clr_addr;
   assign w_clr_val      = r_clr_val;
   assign bus.host_ready = !w_full & (r_state == StIdle);
   assign bus.clr_busy   = (r_state != StIdle);
`else
   logic w_unused_clr;

   assign w_unused_clr   = ^{bus.clr_start, bus.clr_value};
   assign w_clr_slot     = 1'b0;
   assign w_clr_addr     = '0;
   assign w_clr_val      = '0;
   assign bus.host_ready = !w_full;
   assign bus.clr_busy   = 1'b0;
`endif

   always_comb begin
      bus.sram_we    = 1'b0;
      bus.sram_addr  = w_head_addr;
      bus.sram_wdata = '0;
      if (bus.disp_req) begin
         bus.sram_addr = bus.disp_addr;
      end else if (!w_empty) begin
         bus.sram_we = w_head_we;
         if (w_head_we) bus.sram_wdata = w_head_wdata;
      end else if (w_clr_slot) begin
         bus.sram_addr  = w_clr_addr;
         bus.sram_we    = 1'b1;
         bus.sram_wdata = w_clr_val;
      end
   end
endmodule

// File: tb/tb_vram_arbiter.sv
// Scoreboard bench for vram_arbiter with a behavioural 2048x8 synchronous VRAM model.
module tb_vram_arbiter;
   localparam int AW = 11;
   localparam int DW = 8;

   logic clk = 1'b0;
   logic rst = 1'b1;
   bit   preload = 1'b1;

   always #5 clk = ~clk;

   vram_arbiter_if #(.AW(AW), .DW(DW)) bus ();

   vram_arbiter #(.AW(AW), .DW(DW), .DEPTH(4)) dut (
      .clk (clk),
      .rst (rst),
      .bus (bus)
   );

   logic [7:0] mem     [2048];
   logic [7:0] exp_mem [2048];
   logic [7:0] rd_q[$];
   logic [7:0] disp_q[$];

   int  n_tests = 0;
   int  n_fail  = 0;
   int  we_count = 0;
   int  rvalid_count = 0;
   bit  disp_chk_en = 1'b1;
   bit  prev_disp = 1'b0;

   // VRAM macro model: registered read, write-first-cycle store.
   always @(posedge clk) begin
      if (preload) begin
         for (int i = 0; i < 2048; i++) mem[i] <= 8'(i) ^ 8'h5A;
      end else if (bus.sram_we) begin
         mem[bus.sram_addr] <= bus.sram_wdata;
      end
      bus.sram_rdata <= mem[bus.sram_addr];
   end

   always @(posedge clk) begin
      prev_disp <= bus.disp_req && disp_chk_en && !rst;
      if (bus.disp_req && disp_chk_en && !rst) disp_q.push_back(exp_mem[bus.disp_addr]);
   end

   always @(negedge clk) begin
      logic [7:0] e;
      if (bus.sram_we) we_count++;
      if (!rst && bus.host_rvalid) begin
         rvalid_count++;
         n_tests++;
         if (rd_q.size() == 0) begin
            n_fail++;
            $display("FAIL host_rdata: unexpected rvalid, got %h, expected no response",
                     bus.host_rdata);
         end else begin
            e = rd_q.pop_front();
            if (bus.host_rdata !== e) begin
               n_fail++;
               $display("FAIL host_rdata: got %h, expected %h", bus.host_rdata, e);
            end
         end
      end
      if (prev_disp) begin
         n_tests++;
         if (disp_q.size() == 0) begin
            n_fail++;
            $display("FAIL disp_data: no expectation queued, got %h", bus.disp_data);
         end else begin
            e = disp_q.pop_front();
            if (bus.disp_data !== e) begin
               n_fail++;
               $display("FAIL disp_data: got %h, expected %h", bus.disp_data, e);
            end
         end
      end
   end

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic host_cmd(input logic we, input logic [10:0] addr, input logic [7:0] wd,
                           output int waits);
      bit accepted = 1'b0;
      waits = 0;
      bus.host_valid = 1'b1;
      bus.host_we    = we;
      bus.host_addr  = addr;
      bus.host_wdata = wd;
      while (!accepted && waits < 200) begin
         @(negedge clk);
         if (bus.host_ready) begin
            accepted = 1'b1;
            if (we) exp_mem[addr] = wd;
            else    rd_q.push_back(exp_mem[addr]);
         end else begin
            waits++;
         end
         tick();
      end
      bus.host_valid = 1'b0;
      if (!accepted) begin
         n_tests++;
         n_fail++;
         $display("FAIL host_handshake: addr %h not accepted after %0d cycles, expected accept",
                  addr, waits);
      end
   endtask

   task automatic test_reset();
      bus.disp_req = 1'b0; bus.disp_addr = '0;
      bus.host_valid = 1'b0; bus.host_we = 1'b0; bus.host_addr = '0; bus.host_wdata = '0;
      bus.clr_start = 1'b0; bus.clr_value = '0;
      for (int i = 0; i < 2048; i++) exp_mem[i] = 8'(i) ^ 8'h5A;
      rst = 1'b1;
      repeat (3) tick();
      @(negedge clk);
      n_tests++;
      if (bus.host_ready !== 1'b1) begin n_fail++;
         $display("FAIL reset_host_ready: got %b, expected 1", bus.host_ready); end
      n_tests++;
      if (bus.sram_we !== 1'b0) begin n_fail++;
         $display("FAIL reset_sram_we: got %b, expected 0", bus.sram_we); end
      n_tests++;
      if (bus.clr_busy !== 1'b0) begin n_fail++;
         $display("FAIL reset_clr_busy: got %b, expected 0", bus.clr_busy); end
      n_tests++;
      if (bus.host_rvalid !== 1'b0) begin n_fail++;
         $display("FAIL reset_host_rvalid: got %b, expected 0", bus.host_rvalid); end
      n_tests++;
      if (bus.disp_data !== 8'h00) begin n_fail++;
         $display("FAIL reset_disp_data: got %h, expected 00", bus.disp_data); end
      tick();
      rst = 1'b0;
      preload = 1'b0;
      tick();
      @(negedge clk);
      n_tests++;
      if (bus.host_rdata !== bus.sram_rdata) begin n_fail++;
         $display("FAIL reset_rdata_pass: got %h, expected %h", bus.host_rdata, bus.sram_rdata);
      end
      n_tests++;
      if (bus.host_ready !== 1'b1 || bus.disp_data !== 8'h00) begin n_fail++;
         $display("FAIL post_reset: ready %b data %h, expected 1 00", bus.host_ready,
                  bus.disp_data); end
      tick();
   endtask

   task automatic test_display();
      for (int i = 0; i < 64; i++) begin
         bus.disp_req  = 1'b1;
         bus.disp_addr = 11'(i);
         tick();
      end
      bus.disp_req = 1'b0;
      tick();
      tick();
      n_tests++;
      if (disp_q.size() != 0) begin n_fail++;
         $display("FAIL display_drain: %0d left, expected 0", disp_q.size()); end
   endtask

   task automatic test_host_rw();
      int w0, w1, rv0;
      rv0 = rvalid_count;
      host_cmd(1'b1, 11'h123, 8'h41, w0);
      host_cmd(1'b0, 11'h123, 8'h00, w1);
      repeat (6) tick();
      n_tests++;
      if (rvalid_count - rv0 != 1) begin n_fail++;
         $display("FAIL host_rw_pulses: got %0d, expected 1", rvalid_count - rv0); end
      n_tests++;
      if (w0 + w1 != 0) begin n_fail++;
         $display("FAIL host_rw_ready: stalled %0d cycles, expected 0", w0 + w1); end
   endtask

   task automatic test_contention();
      int we0, we_win, stall_at, w;
      we0 = we_count;
      we_win = -1;
      stall_at = -1;
      fork
         begin
            for (int i = 0; i < 10; i++) begin
               bus.disp_req  = 1'b1;
               bus.disp_addr = 11'(12'h040 + i);
               tick();
            end
            bus.disp_req = 1'b0;
            we_win = we_count - we0;
         end
         begin
            for (int i = 0; i < 6; i++) begin
               host_cmd(1'b1, 11'(12'h200 + i), 8'(8'hA0 + i), w);
               if (w > 0 && stall_at < 0) stall_at = i;
            end
         end
      join
      n_tests++;
      if (stall_at != 4) begin n_fail++;
         $display("FAIL contention_stall: ready dropped after %0d pushes, expected 4", stall_at);
      end
      n_tests++;
      if (we_win != 0) begin n_fail++;
         $display("FAIL contention_we: %0d writes during display, expected 0", we_win); end
      repeat (12) tick();
      for (int i = 0; i < 6; i++) begin
         n_tests++;
         if (mem[12'h200 + i] !== 8'(8'hA0 + i)) begin n_fail++;
            $display("FAIL contention_land[%0d]: got %h, expected %h", i, mem[12'h200 + i],
                     8'(8'hA0 + i)); end
      end
      host_cmd(1'b0, 11'h200, 8'h00, w);
      host_cmd(1'b0, 11'h205, 8'h00, w);
      repeat (6) tick();
   endtask

   task automatic test_hold();
      int w;
      host_cmd(1'b1, 11'h010, 8'h77, w);
      repeat (4) tick();
      bus.disp_req  = 1'b1;
      bus.disp_addr = 11'h010;
      tick();
      bus.disp_req = 1'b0;
      fork
         begin
            host_cmd(1'b0, 11'h300, 8'h00, w);
            host_cmd(1'b0, 11'h301, 8'h00, w);
            host_cmd(1'b0, 11'h302, 8'h00, w);
         end
         begin
            for (int k = 0; k < 8; k++) begin
               @(negedge clk);
               n_tests++;
               if (bus.disp_data !== 8'h77) begin n_fail++;
                  $display("FAIL hold[%0d]: got %h, expected 77", k, bus.disp_data); end
               @(posedge clk);
            end
         end
      join
      tick();
      bus.disp_req  = 1'b1;
      bus.disp_addr = 11'h011;
      tick();
      bus.disp_req = 1'b0;
      tick();
      @(negedge clk);
      n_tests++;
      if (bus.disp_data !== 8'h4B) begin n_fail++;
         $display("FAIL hold_update: got %h, expected 4b", bus.disp_data); end
      tick();
   endtask

`ifdef VRAM_CLEAR_EN
   task automatic test_clear();
      int  w, ready_bad, bad_bytes;
      bit  done, prev_last;
      disp_chk_en = 1'b0;
      ready_bad = 0; bad_bytes = 0; done = 1'b0; prev_last = 1'b0;
      host_cmd(1'b1, 11'h500, 8'h11, w);
      host_cmd(1'b1, 11'h501, 8'h12, w);
      bus.clr_start = 1'b1;
      bus.clr_value = 8'h20;
      tick();
      bus.clr_start = 1'b0;
      for (int cyc = 0; cyc < 6000 && !done; cyc++) begin
         bus.disp_req  = (cyc % 7 == 0);
         bus.disp_addr = 11'(cyc);
         bus.clr_start = (cyc == 500);
         bus.clr_value = (cyc == 500) ? 8'h99 : 8'h20;
         @(negedge clk);
         if (bus.clr_busy && bus.host_ready) ready_bad++;
         if (prev_last) begin
            n_tests++;
            if (bus.clr_busy !== 1'b0) begin n_fail++;
               $display("FAIL clear_busy_fall: got %b after 7ff write, expected 0",
                        bus.clr_busy); end
         end
         prev_last = bus.sram_we && (bus.sram_addr == 11'h7FF);
         if (!bus.clr_busy) done = 1'b1;
         tick();
      end
      bus.disp_req = 1'b0;
      bus.clr_start = 1'b0;
      n_tests++;
      if (!done) begin n_fail++;
         $display("FAIL clear_timeout: busy still %b, expected 0", bus.clr_busy); end
      n_tests++;
      if (ready_bad != 0) begin n_fail++;
         $display("FAIL clear_ready: high %0d busy cycles, expected 0", ready_bad); end
      repeat (3) tick();
      for (int i = 0; i < 2048; i++) if (mem[i] !== 8'h20) bad_bytes++;
      n_tests++;
      if (bad_bytes != 0) begin n_fail++;
         $display("FAIL clear_fill: %0d bytes differ, expected 0", bad_bytes); end
      n_tests++;
      if (bus.clr_busy !== 1'b0) begin n_fail++;
         $display("FAIL clear_restart: busy %b, expected 0", bus.clr_busy); end
      for (int i = 0; i < 2048; i++) exp_mem[i] = 8'h20;
      disp_chk_en = 1'b1;
   endtask
`else
   task automatic test_clear();
      bus.clr_start = 1'b1;
      bus.clr_value = 8'h20;
      tick();
      bus.clr_start = 1'b0;
      @(negedge clk);
      n_tests++;
      if (bus.clr_busy !== 1'b0 || bus.host_ready !== 1'b1) begin n_fail++;
         $display("FAIL clear_disabled: busy %b ready %b, expected 0 1", bus.clr_busy,
                  bus.host_ready); end
      tick();
   endtask
`endif

   task automatic test_reset_mid();
      int w, we0, rv0;
      logic [7:0] old0;
      disp_chk_en = 1'b0;
      old0 = exp_mem[11'h600];
      bus.disp_req  = 1'b1;
      bus.disp_addr = 11'h000;
      host_cmd(1'b1, 11'h600, 8'hC3, w);
      host_cmd(1'b1, 11'h601, 8'hC4, w);
      host_cmd(1'b0, 11'h602, 8'h00, w);
      bus.clr_start = 1'b1;
      bus.clr_value = 8'h55;
      tick();
      bus.clr_start = 1'b0;
      rst = 1'b1;
      tick();
      @(negedge clk);
      n_tests++;
      if (bus.clr_busy !== 1'b0 || bus.host_rvalid !== 1'b0 || bus.host_ready !== 1'b1) begin
         n_fail++;
         $display("FAIL rst_mid: busy %b rvalid %b ready %b, expected 0 0 1", bus.clr_busy,
                  bus.host_rvalid, bus.host_ready); end
      tick();
      rst = 1'b0;
      bus.disp_req = 1'b0;
      rd_q.delete();
      we0 = we_count;
      rv0 = rvalid_count;
      repeat (20) tick();
      n_tests++;
      if (we_count != we0) begin n_fail++;
         $display("FAIL rst_mid_we: %0d writes after reset, expected 0", we_count - we0); end
      n_tests++;
      if (rvalid_count != rv0) begin n_fail++;
         $display("FAIL rst_mid_rvalid: %0d pulses, expected 0", rvalid_count - rv0); end
      n_tests++;
      if (mem[11'h600] !== old0) begin n_fail++;
         $display("FAIL rst_mid_mem: got %h, expected %h", mem[11'h600], old0); end
      n_tests++;
      if (bus.host_ready !== 1'b1 || bus.clr_busy !== 1'b0) begin n_fail++;
         $display("FAIL rst_mid_idle: ready %b busy %b, expected 1 0", bus.host_ready,
                  bus.clr_busy); end
      exp_mem[11'h600] = mem[11'h600];
      exp_mem[11'h601] = mem[11'h601];
      disp_chk_en = 1'b1;
   endtask

   initial begin
      #2ms;
      $display("FAIL watchdog: simulation did not finish in time");
      $fatal(1, "watchdog");
   end

   initial begin
      test_reset();
      test_display();
      test_host_rw();
      test_contention();
      test_hold();
      test_clear();
      test_reset_mid();
      n_tests++;
      if (rd_q.size() != 0) begin n_fail++;
         $display("FAIL read_drain: %0d responses missing, expected 0", rd_q.size()); end
      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end
endmodule
